// File: rtl/imem_fetch_resp.sv
// Instruction-memory responder: fixed-latency array read feeding an in-order
// response queue, with credit-based request flow control and redirect flush.
module imem_fetch_resp #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LAT        = 2,
  parameter int QDEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [15:0] req_addr,
  output logic        req_ready,
  input  logic        flush,
  output logic        resp_valid,
  output logic [15:0] resp_inst,
  output logic [15:0] resp_addr,
  output logic        resp_err,
  input  logic        resp_ready,
  input  logic        ld_en,
  input  logic [15:0] ld_addr,
  input  logic [15:0] ld_data
);

  localparam int          WORDS = 1 << DEPTH_LOG2;
  localparam int          PW    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int          CW    = $clog2(QDEPTH + 1);
  localparam logic [15:0] NOP   = 16'h0800;

  typedef struct packed {
    logic [15:0] inst;
    logic [15:0] addr;
    logic        err;
  } word_t;

  logic [15:0]           mem [WORDS];
  word_t                 q_mem [QDEPTH];
  word_t                 stg_q [LAT];
  word_t                 stg_d [LAT];
  logic [LAT-1:0]        vld_q, vld_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d, credit_q, credit_d;
  logic [DEPTH_LOG2-1:0] rd_idx, ld_idx;
  logic                  accept, push, pop;
  word_t                 rd_word, head;

  // Address bits above the word index alias; the byte bit of a load is ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[15:DEPTH_LOG2+1], ld_addr[15:DEPTH_LOG2+1], ld_addr[0]};

  assign rd_idx = req_addr[DEPTH_LOG2:1];
  assign ld_idx = ld_addr[DEPTH_LOG2:1];

  assign req_ready  = ~flush & (credit_q < CW'(QDEPTH)) & rst;
  assign accept     = req_valid & req_ready;
  assign resp_valid = (count_q != '0);
  assign pop        = resp_valid & resp_ready & ~flush;
  assign push       = vld_q[LAT-1] & ~flush;

  assign head      = q_mem[rd_ptr_q];
  assign resp_inst = resp_valid ? head.inst : '0;
  assign resp_addr = resp_valid ? head.addr : '0;
  assign resp_err  = resp_valid & head.err;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    return (ptr == PW'(QDEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  always_comb begin
    rd_word.addr = req_addr;
    rd_word.err  = req_addr[0];
    rd_word.inst = req_addr[0] ? NOP : mem[rd_idx];
  end

  always_comb begin
    vld_d[0] = accept;
    stg_d[0] = rd_word;
    for (int i = 1; i < LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      stg_d[i] = stg_q[i-1];
    end
    if (flush) vld_d = '0;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    credit_d = credit_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      credit_d = '0;
    end else begin
      if (push) wr_ptr_d = next_ptr(wr_ptr_q);
      if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
      count_d  = count_q + CW'(push) - CW'(pop);
      credit_d = credit_q + CW'(accept) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      credit_q <= '0;
    end else begin
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      credit_q <= credit_d;
    end
  end

  // NOTE: storage arrays carry no reset; only the valid/pointer/count state does,
  // so the array keeps its program across reset and outputs are gated by resp_valid.
  always_ff @(posedge clk) begin
    if (ld_en) mem[ld_idx] <= ld_data;
    if (push)  q_mem[wr_ptr_q] <= stg_q[LAT-1];
    for (int i = 0; i < LAT; i++) stg_q[i] <= stg_d[i];
  end

endmodule
